// File: rtl/mac_accum.sv
// Pipelined multiply-accumulate for tap-serial convolution with rounding, scaling and a held output.
// Optional saturation of the scaled result is enabled with the MAC_SAT_EN macro (wraps when undefined).
module mac_accum #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned COEF_WIDTH = 16,
  parameter int unsigned ACC_WIDTH  = 40,
  parameter int unsigned OUT_WIDTH  = 16,
  parameter int unsigned SHIFT      = 15
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         acc_clr,
  input  logic                         cnt,
  input  logic                         conv_pass,
  input  logic signed [DATA_WIDTH-1:0] data_word,
  input  logic signed [COEF_WIDTH-1:0] coef_word,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic        [OUT_WIDTH-1:0]  sample_out,
  output logic                         busy,
  output logic                         ovf
);

  localparam int unsigned PROD_W = DATA_WIDTH + COEF_WIDTH;
  localparam int unsigned RND_W  = ACC_WIDTH + 1;
  localparam logic [RND_W-1:0] HALF = RND_W'(1) << (SHIFT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_FLUSH = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic                   v1_q, v1_d, last1_q, last1_d;
  logic                   v2_q, v2_d, last2_q, last2_d;
  logic                   done_q, done_d;
  logic                   first_q, first_d;
  logic [ACC_WIDTH-1:0]   prod_q, prod_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic                   out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0]   sample_q, sample_d;
  logic                   ovf_q, ovf_d;
  logic                   busy_q, busy_d;

  logic signed [PROD_W-1:0] prod_full_c;
  logic [RND_W-1:0]         rnd_c;
  logic [OUT_WIDTH-1:0]     scaled_c;

  // Round half up, then scale down to the output width.
  always_comb begin
    prod_full_c = PROD_W'(data_word) * PROD_W'(coef_word);
    rnd_c       = {acc_q[ACC_WIDTH-1], acc_q} + HALF;
  end

`ifdef MAC_SAT_EN
  localparam int unsigned HI_W = RND_W - OUT_WIDTH + 1;
  logic signed [RND_W-1:0] shr_c;
  logic [HI_W-1:0]         hi_c;
  always_comb begin
    shr_c = $signed(rnd_c) >>> SHIFT;
    hi_c  = shr_c[RND_W-1:OUT_WIDTH-1];
    if ((&hi_c) || !(|hi_c)) begin
      scaled_c = shr_c[OUT_WIDTH-1:0];
    end else if (shr_c[RND_W-1]) begin
      scaled_c = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    end else begin
      scaled_c = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end
  end
`else
  always_comb begin
    scaled_c = OUT_WIDTH'($signed(rnd_c) >>> SHIFT);
  end
`endif

  // Pipeline, accumulator, output holding register and control FSM next-state.
  always_comb begin
    state_d     = state_q;
    v1_d        = cnt;
    last1_d     = cnt & conv_pass;
    v2_d        = v1_q;
    last2_d     = last1_q;
    done_d      = v2_q & last2_q;
    prod_d      = prod_q;
    acc_d       = acc_q;
    first_d     = first_q;
    out_valid_d = out_valid_q;
    sample_d    = sample_q;
    ovf_d       = ovf_q;

    if (v1_q) begin
      prod_d = {{(ACC_WIDTH-PROD_W){prod_full_c[PROD_W-1]}}, prod_full_c};
    end

    if (v2_q) begin
      acc_d   = first_q ? prod_q : acc_q + prod_q;
      first_d = last2_q;
    end

    if (done_q) begin
      if (out_valid_q && !out_ready) begin
        ovf_d = 1'b1;
      end else begin
        sample_d    = scaled_c;
        out_valid_d = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (cnt) state_d = conv_pass ? S_FLUSH : S_ACCUM;
      end
      S_ACCUM: begin
        if (cnt && conv_pass) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (cnt)         state_d = conv_pass ? S_FLUSH : S_ACCUM;
        else if (done_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // acc_clr flushes everything except the last delivered sample value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      v1_q        <= 1'b0;
      last1_q     <= 1'b0;
      v2_q        <= 1'b0;
      last2_q     <= 1'b0;
      done_q      <= 1'b0;
      prod_q      <= '0;
      acc_q       <= '0;
      first_q     <= 1'b1;
      out_valid_q <= 1'b0;
      sample_q    <= '0;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else if (acc_clr) begin
      state_q     <= S_IDLE;
      v1_q        <= 1'b0;
      last1_q     <= 1'b0;
      v2_q        <= 1'b0;
      last2_q     <= 1'b0;
      done_q      <= 1'b0;
      prod_q      <= '0;
      acc_q       <= '0;
      first_q     <= 1'b1;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      v1_q        <= v1_d;
      last1_q     <= last1_d;
      v2_q        <= v2_d;
      last2_q     <= last2_d;
      done_q      <= done_d;
      prod_q      <= prod_d;
      acc_q       <= acc_d;
      first_q     <= first_d;
      out_valid_q <= out_valid_d;
      sample_q    <= sample_d;
      ovf_q       <= ovf_d;
      busy_q      <= busy_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign sample_out = sample_q;
  assign busy       = busy_q;
  assign ovf        = ovf_q;

endmodule
